// File: rtl/puzzle_pkg.sv
// Shared definitions for the puzzle game: button count, button indices and
// the per-channel auto-repeat state encoding.
package puzzle_pkg;

    localparam int N_BTN = 5;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_OK    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        RPT   = 2'd2
    } rpt_state_t;

    function automatic int int_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_cond_if.sv
// Button bundle between the raw pins, the conditioner and the game logic.
// rel carries the release pulses (release is a reserved word in SystemVerilog).
interface btn_cond_if #(
    parameter int N = puzzle_pkg::N_BTN
);
    logic [N-1:0] btn;
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] rel;

    modport master (
        output btn,
        input  level,
        input  press,
        input  rel
    );

    modport slave (
        input  btn,
        output level,
        output press,
        output rel
    );
endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce counter, press/release
// pulses and, with BTN_AUTOREPEAT_EN defined, a hold-to-repeat FSM.
module btn_debounce_ch
    import puzzle_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 200000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press,
    output logic rel
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic [DW-1:0] db_cnt_reg;
    logic          level_reg;
    logic          press_reg;
    logic          rel_reg;

    logic raw;
    logic settled;
    logic rise;
    logic fall;

    // Pins are active-low; synchroniser idles at the released value.
    assign raw     = ~sync2_reg;
    assign settled = (raw != level_reg) && (db_cnt_reg == DW'(DEBOUNCE_CYCLES - 1));
    assign rise    = settled && !level_reg;
    assign fall    = settled && level_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg  <= 1'b1;
            sync2_reg  <= 1'b1;
            db_cnt_reg <= '0;
            level_reg  <= 1'b0;
            rel_reg    <= 1'b0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
            if (raw == level_reg) begin
                db_cnt_reg <= '0;
            end else if (settled) begin
                level_reg  <= ~level_reg;
                db_cnt_reg <= '0;
            end else begin
                db_cnt_reg <= db_cnt_reg + 1'b1;
            end
            rel_reg <= fall;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RW = $clog2(int_max(REPEAT_DELAY, REPEAT_RATE) + 1);

    rpt_state_t    state_reg;
    logic [RW-1:0] rpt_cnt_reg;

    // Counter is loaded with period-1 and fires on the cycle it sits at zero,
    // so a pulse lands exactly REPEAT_DELAY / REPEAT_RATE cycles apart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            rpt_cnt_reg <= '0;
            press_reg   <= 1'b0;
        end else begin
            press_reg <= rise;
            case (state_reg)
                IDLE: begin
                    if (rise) begin
                        rpt_cnt_reg <= RW'(REPEAT_DELAY - 1);
                        state_reg   <= DELAY;
                    end
                end
                DELAY, RPT: begin
                    if (fall) begin
                        state_reg <= IDLE;
                    end else if (rpt_cnt_reg == '0) begin
                        press_reg   <= 1'b1;
                        rpt_cnt_reg <= RW'(REPEAT_RATE - 1);
                        state_reg   <= RPT;
                    end else begin
                        rpt_cnt_reg <= rpt_cnt_reg - 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            press_reg <= 1'b0;
        end else begin
            press_reg <= rise;
        end
    end
`endif

    assign level = level_reg;
    assign press = press_reg;
    assign rel   = rel_reg;

endmodule

// File: rtl/btn_cond.sv
// Button conditioner: N_BTN independent debounced channels feeding the game
// logic. Define BTN_AUTOREPEAT_EN to add hold-to-repeat press pulses.
module btn_cond #(
    parameter int N_BTN           = puzzle_pkg::N_BTN,
    parameter int DEBOUNCE_CYCLES = 200000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 10000000
) (
    input logic        clk,
    input logic        rst,
    btn_cond_if.slave  bus
);

    logic [N_BTN-1:0] level_vec;
    logic [N_BTN-1:0] press_vec;
    logic [N_BTN-1:0] rel_vec;

    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
            btn_debounce_ch #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_RATE     (REPEAT_RATE)
            ) u_ch (
                .clk   (clk),
                .rst   (rst),
                .btn   (bus.btn[gi]),
                .level (level_vec[gi]),
                .press (press_vec[gi]),
                .rel   (rel_vec[gi])
            );
        end
    endgenerate

    assign bus.level = level_vec;
    assign bus.press = press_vec;
    assign bus.rel   = rel_vec;

endmodule

// File: doc/btn_cond.md
# btn_cond

Button conditioner sitting directly upstream of the puzzle game logic in `top`: takes the five raw active-low push-button pins, synchronises and debounces each one independently, and emits clean active-high levels plus single-cycle press/release pulses. Optional auto-repeat turns a held button into a periodic press stream so that cursor moves can repeat. Everything downstream of this block consumes only `press`, `release` and `level`, never raw `btn`.

## Interface
- `N_BTN`, 5, number of button channels
- `DEBOUNCE_CYCLES`, 200000, consecutive stable cycles required to accept a new level (≥1)
- `REPEAT_DELAY`, 50000000, cycles from the accepted press to the first repeat pulse (≥1)
- `REPEAT_RATE`, 10000000, cycles between subsequent repeat pulses (≥1)

- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `btn`  in  N_BTN  raw pins, active-low, asynchronous to `clk`
- `level`  out  N_BTN  debounced state, 1 = held
- `press`  out  N_BTN  1-cycle pulse on accepted press (and on each repeat when enabled)
- `release`  out  N_BTN  1-cycle pulse on accepted release

## Operation
- Per channel: 2-flop synchroniser on `btn[i]`, inverted to active-high `raw[i]`.
- Debounce counter per channel, width $clog2(DEBOUNCE_CYCLES+1).
  - `raw == level`: counter cleared to 0.
  - `raw != level` and counter == DEBOUNCE_CYCLES-1: `level` toggles, counter cleared.
  - Otherwise: counter increments.
  - Any single-cycle return to the old value restarts the count; glitches shorter than DEBOUNCE_CYCLES never reach `level`.
- `press[i]` is high in exactly the cycle where `level[i]` goes 0→1. `release[i]` is high in exactly the cycle where it goes 1→0. Both are registered and never high together on one channel.
- Per-channel repeat FSM (macro enabled only):
  - IDLE: `level` 0. A 0→1 transition loads the repeat counter and moves to DELAY.
  - DELAY: counts REPEAT_DELAY cycles. On expiry it pulses `press`, reloads the counter and moves to RPT.
  - RPT: pulses `press` every REPEAT_RATE cycles.
  - From DELAY or RPT, `level` 1→0 returns to IDLE; the `release` pulse occurs and there is no press pulse in that cycle.
- Channels are fully independent; simultaneous presses on several channels all pulse in the same cycle.

## Timing
- Reset (async assert, sync deassert assumed from board-level logic):
  - sync flops = 1 (released).
  - `level` = 0, `press` = 0, `release` = 0.
  - Counters cleared, FSM = IDLE.
- Reset mid-press forces outputs to 0 immediately. After reset, a still-held button is re-accepted after the full debounce and produces a fresh `press`.
- Latency: a pin change settled before rising edge 0 appears on `level`/`press` after rising edge DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 edges.
- First repeat pulse: REPEAT_DELAY cycles after the initial `press` cycle. Subsequent repeat pulses: every REPEAT_RATE cycles.

## Configuration
- `BTN_AUTOREPEAT_EN`
  - Defined: repeat FSM and per-channel repeat counters are present, behaving as above.
  - Undefined: no repeat logic, and `REPEAT_DELAY`/`REPEAT_RATE` are ignored. `press` pulses only once per accepted press.

## Structure
- Shared package `puzzle_pkg` holds:
  - `N_BTN`.
  - Button index constants `BTN_UP`=0, `BTN_DOWN`=1, `BTN_LEFT`=2, `BTN_RIGHT`=3, `BTN_OK`=4.
  - The repeat-FSM state enum `rpt_state_t` {IDLE, DELAY, RPT}.
- One sub-module `btn_debounce_ch` (synchroniser, debounce, edge pulses, optional repeat for one channel), generated N_BTN times by `btn_cond`.

## Test plan
Bench parameters for all scenarios: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.

1. Reset check: hold `rst`=1 with `btn`=5'b11111. Required: `level`=0, `press`=0, `release`=0. Release reset and hold `btn` for 20 cycles; outputs must stay 0.
2. Clean press: drive `btn`=5'b01111 and hold. Required: `level[4]`=1 and a single `press[4]` pulse at edge 5 after the change. Later drive `btn`=5'b11111; required: a single `release[4]` pulse 6 edges after that change.
3. Glitch rejection: toggle `btn[4]` and then `btn[3]` between 0 and 1 every cycle for 30 cycles. Required: no `press`, `release` or `level` activity.
4. Auto-repeat (macro defined): hold `btn[0]`=0 for 30 cycles. Required: `press[0]` pulses at the initial cycle T, then T+10, T+13, T+16, and so on. Without the macro, only the pulse at T occurs.
5. Simultaneous press and reset mid-hold: drive `btn`=5'b00000. Required: all five `press` bits pulse in the same cycle. Then assert `rst` while the buttons are held. Required: outputs go to 0 at once, and after deassertion `press`=5'b11111 fires again after 6 edges.
